cpu_program_loader: RTL and testbench
=====================================

# cpu_program_loader

Host-side programming sequencer for the 8-bit CPU's load-mode handshake. It holds a 16-byte program image written by a host port. On `start` it drives the CPU's `programming` input and presents image bytes on the CPU's `ui_in` bus, paced by the CPU's `ready` and `done_load` outputs. It then releases the CPU to run and reports halt, completion, or protocol error. It sits beside the CPU tile, in the harness or a companion tile, and is clocked from the same `clk`.

## Interface
- `RAM_BYTES`, 16: number of bytes transferred per load; image depth.
- `TIMEOUT`, 255: max cycles spent in any handshake wait state before error; 8-bit counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `img_we` in 1: image write strobe; ignored while `busy`.
- `img_addr` in 4: image write address.
- `img_data` in 8: image write data.
- `start` in 1: single-cycle start pulse; accepted only in IDLE, HALTED or ERROR.
- `cpu_ready` in 1: CPU ready-for-byte, to CPU `uio_out[1]`.
- `cpu_done_load` in 1: CPU load complete, to CPU `uio_out[2]`.
- `cpu_halt` in 1: CPU halt flag, to CPU `uio_out[5]`.
- `cpu_programming` out 1: programming-mode request, to CPU `uio_in[0]`.
- `cpu_ui_in` out 8: program byte, to CPU `ui_in`.
- `busy` out 1: high in WAIT_READY, PRESENT and WAIT_DONE.
- `running` out 1: high in RUN.
- `halted` out 1: high in HALTED.
- `error` out 1: high in ERROR.
- `byte_count` out 5: bytes handed over in the current or last load.

## Operation
- Image: 16×8 flops. A write on `img_we` lands at `img_addr` on the next edge when not `busy`. Reads are asynchronous via pointer `ptr`.
- `cpu_ui_in` = image[`ptr`] whenever `cpu_programming`=1, else 8'h00.
- `cpu_programming` is registered. It is 1 in WAIT_READY, PRESENT and WAIT_DONE, and 0 otherwise.
- States and transitions:
  - **IDLE**: on `start`, go to WAIT_READY. Clear `ptr`, `byte_count` and the timeout counter.
  - **WAIT_READY**:
    - `cpu_ready`=1: go to PRESENT.
    - `cpu_done_load`=1 (too early): go to ERROR.
    - Timeout: go to ERROR.
  - **PRESENT**: byte is held stable.
    - `cpu_ready`=0: increment `ptr` and `byte_count`.
    - If the new count equals `RAM_BYTES`, go to WAIT_DONE; else go to WAIT_READY.
    - Timeout: go to ERROR.
  - **WAIT_DONE**:
    - `cpu_done_load`=1: go to RUN.
    - `cpu_ready`=1 (CPU requests an extra byte): go to ERROR.
    - Timeout: go to ERROR.
  - **RUN**: `cpu_halt`=1 goes to HALTED. No timeout applies. `start` is ignored.
  - **HALTED** and **ERROR**: hold until `start`, which re-enters WAIT_READY with a fresh load.
- Check priority within one cycle: error conditions first, then timeout, then the normal transition.
- The timeout counter clears on every state change. It increments each cycle in wait states. Reaching `TIMEOUT` triggers the error.
- `ptr` is 4 bits and wraps 15→0. That wrap coincides only with the WAIT_DONE transition.
- A `start` while `busy` or in RUN has no effect.

## Timing
- Reset (asynchronous) values:
  - State is IDLE.
  - `cpu_programming`, `busy`, `running`, `halted` and `error` are 0.
  - `cpu_ui_in` is 0.
  - `byte_count` and `ptr` are 0.
  - Image is all 0.
- Reset mid-load drops `cpu_programming` immediately (asynchronously) and abandons the transfer. The image is cleared.
- `start` in cycle N:
  - State is WAIT_READY at N+1.
  - `cpu_programming`=1 at N+1.
  - `cpu_ui_in` = image[0] at N+1.
- A byte is valid on `cpu_ui_in` at least one cycle before `cpu_ready` can rise. It stays stable until the cycle after `cpu_ready` is sampled low.
- `cpu_ready` is sampled low at edge M:
  - `ptr` and `byte_count` update at M.
  - The next byte appears at M+ (combinational from `ptr`).
- `cpu_done_load` is sampled at edge D in WAIT_DONE: `cpu_programming`=0 and `running`=1 after D.
- All CPU-side inputs are in the `clk` domain. No synchronizers.

## Test plan
- **Normal load.** Image = 8'h10+i for i=0..15; `start`; CPU model pulses `ready` 2 cycles high, 1 low, 16 times, then `done_load`.
  - Each byte is seen as 8'h10..8'h1F in order.
  - `byte_count` ends at 16.
  - `running`=1 and `cpu_programming`=0 one cycle after `done_load`.
- **Halt.** From RUN, assert `cpu_halt`: `halted`=1 next cycle. A second `start` reloads, with `byte_count` restarting at 0.
- **Early done.** `done_load` after 5 bytes: `error`=1 with `byte_count`=5.
- **Extra request.** `ready` asserted in WAIT_DONE: `error`=1, and `cpu_programming` drops the next cycle.
- **Timeout and restart.** `cpu_ready` is never raised after `start`: `error`=1 exactly `TIMEOUT` (255) cycles into WAIT_READY. A following `start` recovers.
- **Write-protect and reset.**
  - `img_we` during a load leaves the image unchanged, verified by re-load.
  - `rst_n`=0 mid-PRESENT immediately forces `cpu_programming`=0 and all status outputs to 0.

Source files
------------

// File: rtl/cpu_program_loader.sv
// cpu_program_loader
// Host-side programming sequencer for the 8-bit CPU load-mode handshake.
// A host fills a 16-byte image. On start, the sequencer raises
// cpu_programming and hands the image out one byte at a time on cpu_ui_in.
// The CPU paces the transfer with cpu_ready and ends it with cpu_done_load.
// The CPU is then released to run. Halt, completion and protocol errors
// are reported on the status outputs.
//
// Ports
//   clk, rst_n        : clock (rising edge), async active-low reset
//   img_we/addr/data  : host image write port, ignored while busy
//   start             : load request, honoured in IDLE, HALTED and ERROR
//   cpu_ready         : CPU asks for a byte (high) / has taken it (low)
//   cpu_done_load     : CPU has finished loading
//   cpu_halt          : CPU has halted
//   cpu_programming   : load-mode request to the CPU
//   cpu_ui_in         : program byte presented to the CPU
//   busy/running/halted/error : sequencer status
//   byte_count        : bytes handed over in the current or last load
module cpu_program_loader #(
    parameter int RAM_BYTES = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       img_we,
    input  logic [3:0] img_addr,
    input  logic [7:0] img_data,
    input  logic       start,
    input  logic       cpu_ready,
    input  logic       cpu_done_load,
    input  logic       cpu_halt,
    output logic       cpu_programming,
    output logic [7:0] cpu_ui_in,
    output logic       busy,
    output logic       running,
    output logic       halted,
    output logic       error,
    output logic [4:0] byte_count
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_PRESENT    = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_RUN        = 3'd4,
        ST_HALTED     = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

    localparam logic [4:0] LAST_COUNT = 5'(RAM_BYTES);
    // Timeout fires on the cycle whose increment would reach TIMEOUT, so the
    // error lands exactly TIMEOUT cycles after entering a wait state.
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t     state_r;
    state_t     state_s;
    logic [3:0] ptr_r;
    logic [7:0] tmo_cnt_r;
    logic [7:0] image_r [RAM_BYTES];
    logic       tmo_hit_s;
    logic       ptr_inc_s;
    logic       load_clr_s;
    logic       waiting_s;
    logic       waiting_next_s;

    assign tmo_hit_s      = (tmo_cnt_r == TMO_LAST);
    assign waiting_s      = (state_r == ST_WAIT_READY) || (state_r == ST_PRESENT) ||
                            (state_r == ST_WAIT_DONE);
    assign waiting_next_s = (state_s == ST_WAIT_READY) || (state_s == ST_PRESENT) ||
                            (state_s == ST_WAIT_DONE);

    // Byte mux toward the CPU; the bus idles at zero outside load mode.
    assign cpu_ui_in = cpu_programming ? image_r[ptr_r] : 8'h00;

    // Next-state logic: protocol errors win over timeout, timeout over progress.
    always_comb begin
        state_s    = state_r;
        ptr_inc_s  = 1'b0;
        load_clr_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
                if (start) begin
                    state_s    = ST_WAIT_READY;
                    load_clr_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT_READY: begin
                if (cpu_done_load) begin
                    state_s = ST_ERROR;
                end else if (tmo_hit_s) begin
                    state_s = ST_ERROR;
                end else if (cpu_ready) begin
                    state_s = ST_PRESENT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PRESENT: begin
                if (tmo_hit_s) begin
                    state_s = ST_ERROR;
                end else if (!cpu_ready) begin
                    ptr_inc_s = 1'b1;
                    if ((byte_count + 5'd1) == LAST_COUNT) begin
                        state_s = ST_WAIT_DONE;
                    end else begin
                        state_s = ST_WAIT_READY;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT_DONE: begin
                if (cpu_ready) begin
                    state_s = ST_ERROR;
                end else if (tmo_hit_s) begin
                    state_s = ST_ERROR;
                end else if (cpu_done_load) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (cpu_halt) begin
                    state_s = ST_HALTED;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            ptr_r           <= 4'd0;
            byte_count      <= 5'd0;
            tmo_cnt_r       <= 8'd0;
            cpu_programming <= 1'b0;
            busy            <= 1'b0;
            running         <= 1'b0;
            halted          <= 1'b0;
            error           <= 1'b0;
        end else begin
            state_r <= state_s;
            if (load_clr_s) begin
                ptr_r      <= 4'd0;
                byte_count <= 5'd0;
            end else if (ptr_inc_s) begin
                ptr_r      <= ptr_r + 4'd1;
                byte_count <= byte_count + 5'd1;
            end else begin
                ptr_r      <= ptr_r;
                byte_count <= byte_count;
            end
            if ((state_s != state_r) || !waiting_s) begin
                tmo_cnt_r <= 8'd0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end
            cpu_programming <= waiting_next_s;
            busy            <= waiting_next_s;
            running         <= (state_s == ST_RUN);
            halted          <= (state_s == ST_HALTED);
            error           <= (state_s == ST_ERROR);
        end
    end

    // Host image store; writes are locked out while a transfer is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_BYTES; i++) begin
                image_r[i] <= 8'h00;
            end
        end else if (img_we && !busy) begin
            image_r[img_addr] <= img_data;
        end else begin
            image_r <= image_r;
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
module tb_cpu_program_loader;

    logic       clk;
    logic       rst_n;
    logic       img_we;
    logic [3:0] img_addr;
    logic [7:0] img_data;
    logic       start;
    logic       cpu_ready;
    logic       cpu_done_load;
    logic       cpu_halt;
    logic       cpu_programming;
    logic [7:0] cpu_ui_in;
    logic       busy;
    logic       running;
    logic       halted;
    logic       error;
    logic [4:0] byte_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] img_model [16];
    logic [7:0] exp_q [$];

    cpu_program_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .img_we         (img_we),
        .img_addr       (img_addr),
        .img_data       (img_data),
        .start          (start),
        .cpu_ready      (cpu_ready),
        .cpu_done_load  (cpu_done_load),
        .cpu_halt       (cpu_halt),
        .cpu_programming(cpu_programming),
        .cpu_ui_in      (cpu_ui_in),
        .busy           (busy),
        .running        (running),
        .halted         (halted),
        .error          (error),
        .byte_count     (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n_bytes;   // bytes fed before the terminating event
        int         evt;       // 0: done_load, 1: early done_load, 2: extra ready
        logic       exp_err;
        logic       exp_run;
        logic [4:0] exp_cnt;
    } vec_t;

    vec_t vecs [4];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic write_img(input logic [3:0] a, input logic [7:0] d);
        img_we   = 1'b1;
        img_addr = a;
        img_data = d;
        step(1);
        img_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // CPU model: ready high two cycles, low one; byte captured in first high cycle.
    task automatic feed_bytes(input int n);
        logic [7:0] exp_b;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(img_model[i]);
            cpu_ready = 1'b1;
            step(1);
            exp_b = exp_q.pop_front();
            check("byte", {24'd0, cpu_ui_in}, {24'd0, exp_b});
            step(1);
            cpu_ready = 1'b0;
            step(1);
        end
    endtask

    task automatic full_load_to_run();
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_cnt", {27'd0, byte_count}, 32'd0);
        feed_bytes(16);
        cpu_done_load = 1'b1;
        step(1);
        cpu_done_load = 1'b0;
        check("run_running", {31'd0, running}, 32'd1);
        check("run_prog", {31'd0, cpu_programming}, 32'd0);
        check("run_cnt", {27'd0, byte_count}, 32'd16);
    endtask

    task automatic do_halt();
        cpu_halt = 1'b1;
        step(1);
        cpu_halt = 1'b0;
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_running", {31'd0, running}, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        img_we        = 1'b0;
        img_addr      = 4'd0;
        img_data      = 8'd0;
        start         = 1'b0;
        cpu_ready     = 1'b0;
        cpu_done_load = 1'b0;
        cpu_halt      = 1'b0;
        step(2);
        check("rst_prog", {31'd0, cpu_programming}, 32'd0);
        check("rst_status", {28'd0, busy, running, halted, error}, 32'd0);
        check("rst_ui", {24'd0, cpu_ui_in}, 32'd0);
        check("rst_cnt", {27'd0, byte_count}, 32'd0);
        rst_n = 1'b1;
        step(1);

        for (int i = 0; i < 16; i++) begin
            img_model[i] = 8'h10 + 8'(i);
            write_img(4'(i), img_model[i]);
        end

        vecs[0] = '{16, 0, 1'b0, 1'b1, 5'd16};
        vecs[1] = '{5,  1, 1'b1, 1'b0, 5'd5};
        vecs[2] = '{16, 2, 1'b1, 1'b0, 5'd16};
        vecs[3] = '{0,  1, 1'b1, 1'b0, 5'd0};

        for (int v = 0; v < 4; v++) begin
            pulse_start();
            check("vec_start_prog", {31'd0, cpu_programming}, 32'd1);
            check("vec_start_ui", {24'd0, cpu_ui_in}, {24'd0, img_model[0]});
            check("vec_start_cnt", {27'd0, byte_count}, 32'd0);
            feed_bytes(vecs[v].n_bytes);
            if (vecs[v].evt == 2) begin
                cpu_ready = 1'b1;
                step(1);
                cpu_ready = 1'b0;
            end else begin
                cpu_done_load = 1'b1;
                step(1);
                cpu_done_load = 1'b0;
            end
            check("vec_error", {31'd0, error}, {31'd0, vecs[v].exp_err});
            check("vec_running", {31'd0, running}, {31'd0, vecs[v].exp_run});
            check("vec_cnt", {27'd0, byte_count}, {27'd0, vecs[v].exp_cnt});
            check("vec_prog", {31'd0, cpu_programming}, 32'd0);
            check("vec_ui", {24'd0, cpu_ui_in}, 32'd0);
            if (vecs[v].exp_run) begin
                do_halt();
            end
        end

        // Timeout: ready never rises.
        pulse_start();
        step(254);
        check("tmo_before", {30'd0, busy, error}, 32'd2);
        step(1);
        check("tmo_error", {31'd0, error}, 32'd1);
        check("tmo_prog", {31'd0, cpu_programming}, 32'd0);

        // Recovery, then start is ignored while running.
        full_load_to_run();
        pulse_start();
        check("run_start_ign", {30'd0, running, busy}, 32'd2);
        check("run_start_cnt", {27'd0, byte_count}, 32'd16);
        do_halt();

        // Write-protect: a write during the load must not land.
        pulse_start();
        write_img(4'd3, 8'hEE);
        feed_bytes(16);
        cpu_done_load = 1'b1;
        step(1);
        cpu_done_load = 1'b0;
        do_halt();
        full_load_to_run();
        do_halt();

        // Reset mid-PRESENT.
        pulse_start();
        cpu_ready = 1'b1;
        step(1);
        rst_n = 1'b0;
        cpu_ready = 1'b0;
        #1;
        check("midrst_prog", {31'd0, cpu_programming}, 32'd0);
        check("midrst_status", {28'd0, busy, running, halted, error}, 32'd0);
        check("midrst_ui", {24'd0, cpu_ui_in}, 32'd0);
        check("midrst_cnt", {27'd0, byte_count}, 32'd0);
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            img_model[i] = 8'h00;
        end
        step(1);
        full_load_to_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
